// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack command controller and its wrapper.
package stack_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Command-side controller for the LIFO storage block: owns the stack pointer,
// strobes push/pop into storage and returns popped words over a response port.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [DEPTH-1:0] stk_pointer,
    output logic [WIDTH-1:0] stk_data_in,
    input  logic [WIDTH-1:0] stk_data_out,
    output logic [DEPTH-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr,
    output state_t           dbg_state
);

    localparam logic [DEPTH-1:0] FULL_LVL = DEPTH'(DEPTH);

    state_t           state;
    logic [DEPTH-1:0] pointer;
    logic             accept;
    logic             do_push;
    logic             do_pop;
    logic             do_clear;
    logic             push_ovf;
    logic             pop_unf;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and an offered response holds until taken.
    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready && !rst;

    assign full  = (pointer == FULL_LVL);
    assign empty = (pointer == '0);

    assign do_push  = accept && (cmd_op == OP_PUSH)  && !full;
    assign do_pop   = accept && (cmd_op == OP_POP)   && !empty;
    assign do_clear = accept && (cmd_op == OP_CLEAR);
    assign push_ovf = accept && (cmd_op == OP_PUSH)  && full;
    assign pop_unf  = accept && (cmd_op == OP_POP)   && empty;

    assign stk_push    = do_push;
    assign stk_pop     = do_pop;
    assign stk_pointer = pointer;
    assign stk_data_in = cmd_data;
    assign level       = pointer;
    assign rsp_valid   = (state == ST_RESP);
    assign rsp_data    = stk_data_out;
    assign dbg_state   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pointer <= '0;
            state   <= ST_IDLE;
        end else begin
            if (do_push) begin
                pointer <= pointer + 1'b1;
            end else if (do_pop) begin
                pointer <= pointer - 1'b1;
            end else if (do_clear) begin
                pointer <= '0;
            end

            case (state)
                ST_IDLE: if (do_pop)    state <= ST_RESP;
                ST_RESP: if (rsp_ready) state <= ST_IDLE;
                default:                state <= ST_IDLE;
            endcase
        end
    end

    // A set event in the same cycle as err_clr keeps the flag raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ovf)     overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;

            if (pop_unf)      underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios then random traffic, checked
// against a queue-based model of stack behaviour.
module tb_stack_ctrl;
    import stack_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             stk_push;
    logic             stk_pop;
    logic [DEPTH-1:0] stk_pointer;
    logic [WIDTH-1:0] stk_data_in;
    logic [WIDTH-1:0] stk_data_out;
    logic [DEPTH-1:0] level;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
    logic             err_clr;
    state_t           dbg_state;

    always #5 clk = ~clk;

    stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_pointer(stk_pointer),
        .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
        .level(level), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr),
        .dbg_state(dbg_state)
    );

    // Storage block stand-in: write at pointer, read entry pointer-1 on pop.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (stk_push) mem[stk_pointer] <= stk_data_in;
        if (stk_pop)  stk_data_out <= mem[stk_pointer - 1'b1];
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    bit               m_resp;
    logic [WIDTH-1:0] m_word;
    bit               m_ovf;
    bit               m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_resp = 0;
        m_ovf  = 0;
        m_unf  = 0;
    endtask

    task automatic check_regs(input string where);
        check({where, " level"},     32'(level),     32'(exp_q.size()));
        check({where, " full"},      32'(full),      32'(exp_q.size() == DEPTH));
        check({where, " empty"},     32'(empty),     32'(exp_q.size() == 0));
        check({where, " overflow"},  32'(overflow),  32'(m_ovf));
        check({where, " underflow"}, 32'(underflow), 32'(m_unf));
        check({where, " rsp_valid"}, 32'(rsp_valid), 32'(m_resp));
        if (m_resp) check({where, " rsp_data"}, 32'(rsp_data), 32'(m_word));
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check state.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] d,
                         input logic rr, input logic ec);
        bit acc, e_push, e_pop, e_ovf, e_unf, pre_resp;
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        rsp_ready = rr;
        err_clr   = ec;
        pre_resp  = m_resp;
        acc    = v && !m_resp;
        e_push = acc && op == OP_PUSH && exp_q.size() < DEPTH;
        e_ovf  = acc && op == OP_PUSH && exp_q.size() == DEPTH;
        e_pop  = acc && op == OP_POP  && exp_q.size() > 0;
        e_unf  = acc && op == OP_POP  && exp_q.size() == 0;
        @(negedge clk);
        check("cmd_ready",   32'(cmd_ready),   32'(!m_resp));
        check("stk_push",    32'(stk_push),    32'(e_push));
        check("stk_pop",     32'(stk_pop),     32'(e_pop));
        check("stk_data_in", 32'(stk_data_in), 32'(d));
        check("pre rsp_valid", 32'(rsp_valid), 32'(m_resp));
        if (m_resp) check("pre rsp_data", 32'(rsp_data), 32'(m_word));
        @(posedge clk);
        if (e_push) exp_q.push_back(d);
        if (e_pop) begin
            m_word = exp_q.pop_back();
            m_resp = 1;
        end
        if (acc && op == OP_CLEAR) exp_q.delete();
        if (pre_resp && rr) m_resp = 0;
        if (e_ovf) m_ovf = 1; else if (ec) m_ovf = 0;
        if (e_unf) m_unf = 1; else if (ec) m_unf = 0;
        #1;
        check_regs("post");
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        err_clr   = 1'b0;
        model_reset();
        #2;
        check("rst stk_push", 32'(stk_push), 32'd0);
        check("rst stk_pop",  32'(stk_pop),  32'd0);
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        check_regs("reset");

        // Push two, pop both.
        cycle(1, OP_PUSH, 8'hA5, 1, 0);
        cycle(1, OP_PUSH, 8'h3C, 1, 0);
        cycle(1, OP_POP,  8'h00, 1, 0);
        cycle(0, OP_NOP,  8'h00, 1, 0);
        cycle(1, OP_POP,  8'h00, 1, 0);
        cycle(0, OP_NOP,  8'h00, 1, 0);

        // Overflow on third push, then pop returns second word.
        cycle(1, OP_PUSH, 8'hA5, 1, 0);
        cycle(1, OP_PUSH, 8'h3C, 1, 0);
        cycle(1, OP_PUSH, 8'h77, 1, 0);
        cycle(1, OP_POP,  8'h00, 1, 0);
        cycle(0, OP_NOP,  8'h00, 1, 0);
        cycle(1, OP_POP,  8'h00, 1, 0);
        cycle(0, OP_NOP,  8'h00, 1, 1);

        // Underflow, clear, then set-wins.
        cycle(1, OP_POP,  8'h00, 1, 0);
        cycle(0, OP_NOP,  8'h00, 1, 1);
        cycle(1, OP_POP,  8'h00, 1, 1);
        cycle(0, OP_NOP,  8'h00, 1, 1);

        // Response held under back-pressure; pushes offered meanwhile are ignored.
        cycle(1, OP_PUSH, 8'h5A, 1, 0);
        cycle(1, OP_POP,  8'h00, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, OP_PUSH, 8'hEE, 0, 0);
        cycle(0, OP_NOP,  8'h00, 1, 0);
        cycle(0, OP_NOP,  8'h00, 1, 0);

        // Clear.
        cycle(1, OP_PUSH,  8'h01, 1, 0);
        cycle(1, OP_PUSH,  8'h02, 1, 0);
        cycle(1, OP_CLEAR, 8'h00, 1, 0);

        // Reset while a response is pending.
        cycle(1, OP_PUSH, 8'h99, 1, 0);
        cycle(1, OP_POP,  8'h00, 0, 0);
        rst = 1'b1;
        #1;
        check("async rsp_valid", 32'(rsp_valid),   32'd0);
        check("async pointer",   32'(stk_pointer), 32'd0);
        check("async cmd_ready", 32'(cmd_ready),   32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_regs("after rst");

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
